// File: rtl/csr_unit_pkg.sv
// Shared types and constants for the machine-mode CSR file.
package csr_unit_pkg;

  localparam logic [31:0] RESET_VECTOR  = 32'h8000_0000;
  localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;
  localparam logic [31:0] MIE_MASK      = 32'h0000_0888;
  localparam int          MSTATUS_MIE   = 3;
  localparam int          MSTATUS_MPIE  = 7;

  localparam logic [3:0] CAUSE_MIS_INST     = 4'd0;
  localparam logic [3:0] CAUSE_ACCESS_INST  = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL      = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK       = 4'd3;
  localparam logic [3:0] CAUSE_MIS_LOAD     = 4'd4;
  localparam logic [3:0] CAUSE_ACCESS_LOAD  = 4'd5;
  localparam logic [3:0] CAUSE_MIS_STORE    = 4'd6;
  localparam logic [3:0] CAUSE_ACCESS_STORE = 4'd7;
  localparam logic [3:0] CAUSE_ECALL        = 4'd11;

  localparam logic [3:0] IRQ_SOFTWARE = 4'd3;
  localparam logic [3:0] IRQ_TIMER    = 4'd7;
  localparam logic [3:0] IRQ_EXTERNAL = 4'd11;

  typedef enum logic [11:0] {
    CSR_MSTATUS   = 12'h300, CSR_MISA     = 12'h301, CSR_MIE    = 12'h304,
    CSR_MTVEC     = 12'h305, CSR_MSCRATCH = 12'h340, CSR_MEPC   = 12'h341,
    CSR_MCAUSE    = 12'h342, CSR_MTVAL    = 12'h343, CSR_MIP    = 12'h344,
    CSR_MCYCLE    = 12'hB00, CSR_MINSTRET = 12'hB02,
    CSR_MVENDORID = 12'hF11, CSR_MARCHID  = 12'hF12, CSR_MIMPID = 12'hF13,
    CSR_MHARTID   = 12'hF14
  } destinationCSR_;

  typedef enum logic [1:0] {CSR_NONE, CSR_RW, CSR_RS, CSR_RC} CSROp_;

  typedef enum logic [3:0] {
    TRAP_MIS_INST     = CAUSE_MIS_INST,    TRAP_ACCESS_INST  = CAUSE_ACCESS_INST,
    TRAP_ILLEGAL      = CAUSE_ILLEGAL,     TRAP_EBREAK       = CAUSE_EBREAK,
    TRAP_MIS_LOAD     = CAUSE_MIS_LOAD,    TRAP_ACCESS_LOAD  = CAUSE_ACCESS_LOAD,
    TRAP_MIS_STORE    = CAUSE_MIS_STORE,   TRAP_ACCESS_STORE = CAUSE_ACCESS_STORE,
    TRAP_ECALL        = CAUSE_ECALL,       TRAP_NONE         = 4'd15
  } trapType_;

  typedef struct packed {
    trapType_    trapType;
    logic [31:0] instruction;
    logic [31:0] faultingAddress;
  } trapPayload_;

  typedef struct packed {
    logic           writeEnable;
    destinationCSR_ writeCSR;
    logic           writeHigh;
    CSROp_          writeOp;
    logic [31:0]    writeOperand;
  } csrWritePort_;

  function automatic logic [31:0] csr_alu(CSROp_ op, logic [31:0] cur, logic [31:0] opnd);
    case (op)
      CSR_RS:  return cur | opnd;
      CSR_RC:  return cur & ~opnd;
      default: return opnd;
    endcase
  endfunction

endpackage

// File: rtl/csr_unit_if.sv
// Execute/writeback <-> CSR file signal bundle.
interface csr_unit_if;
  import csr_unit_pkg::*;

  destinationCSR_ readCSR;
  logic           readHigh;
  logic [31:0]    readData;
  logic           writeEnable;
  destinationCSR_ writeCSR;
  logic           writeHigh;
  CSROp_          writeOp;
  logic [31:0]    writeOperand;
  logic           instructionRetired;
  logic           trapValid;
  logic           trapIsInterrupt;
  logic [31:0]    trapPC;
  trapPayload_    trapPayload;
  logic           mretValid;
  logic           irqSoftware, irqTimer, irqExternal;
  logic [31:0]    trapVector;
  logic [31:0]    mepcOut;
  logic           interruptPending;
  logic [3:0]     interruptCode;

  modport master (
    output readCSR, readHigh, writeEnable, writeCSR, writeHigh, writeOp, writeOperand,
           instructionRetired, trapValid, trapIsInterrupt, trapPC, trapPayload, mretValid,
           irqSoftware, irqTimer, irqExternal,
    input  readData, trapVector, mepcOut, interruptPending, interruptCode
  );

  modport slave (
    input  readCSR, readHigh, writeEnable, writeCSR, writeHigh, writeOp, writeOperand,
           instructionRetired, trapValid, trapIsInterrupt, trapPC, trapPayload, mretValid,
           irqSoftware, irqTimer, irqExternal,
    output readData, trapVector, mepcOut, interruptPending, interruptCode
  );
endinterface

// File: rtl/csr_unit_counter.sv
// WIDTH-bit free-running counter with independently writable 32-bit halves.
module csr_counter #(
  parameter int WIDTH = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        increment,
  input  logic        writeLow,
  input  logic        writeHigh,
  input  logic [31:0] data,
  output logic [63:0] value
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [63:0]      cur, nxt;

  // A written half takes the data; the untouched half holds (no carry that cycle).
  always_comb begin
    cur = 64'(cnt_q);
    nxt = cur + 64'(increment);
    if (writeLow)       nxt = {cur[63:32], data};
    else if (writeHigh) nxt = {data, cur[31:0]};
    cnt_d = WIDTH'(nxt);
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign value = 64'(cnt_q);
endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: registered CSRs, counters, interrupt pending and trap/MRET sequencing.
module csr_unit
  import csr_unit_pkg::*;
#(
  parameter logic [31:0] HART_ID       = 32'd0,
  parameter int          COUNTER_WIDTH = 64,
  parameter logic [31:0] MTVEC_RESET   = RESET_VECTOR,
  parameter logic [31:0] MISA_VALUE    = 32'h4000_0100,
  parameter logic [31:0] VENDOR_ID     = 32'd0,
  parameter logic [31:0] ARCH_ID       = 32'd0,
  parameter logic [31:0] IMP_ID        = 32'd0
) (
  input logic      clock,
  input logic      reset,
  csr_unit_if.slave csr
);
  logic        mie_bit_q, mie_bit_d, mpie_q, mpie_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [31:0] mie_q, mie_d, mscratch_q, mscratch_d, mtvec_q, mtvec_d;
  logic [31:0] mstatus_v, mip, pend, wr_cur, wr_val, trap_val;
  logic [63:0] mcycle_v, minstret_v;
  logic [3:0]  irq_code, trap_code;
  logic        trap_take, write_go;
  csrWritePort_ wp;

  assign wp = '{writeEnable: csr.writeEnable, writeCSR: csr.writeCSR, writeHigh: csr.writeHigh,
                writeOp: csr.writeOp, writeOperand: csr.writeOperand};

  assign mstatus_v = MSTATUS_RESET | (32'(mpie_q) << MSTATUS_MPIE) | (32'(mie_bit_q) << MSTATUS_MIE);
  assign mip  = {20'b0, csr.irqExternal, 3'b0, csr.irqTimer, 3'b0, csr.irqSoftware, 3'b0};
  assign pend = mip & mie_q;

  function automatic logic [31:0] read_csr(destinationCSR_ a, logic hi);
    case (a)
      CSR_MSTATUS:   return mstatus_v;
      CSR_MISA:      return MISA_VALUE;
      CSR_MIE:       return mie_q;
      CSR_MTVEC:     return mtvec_q;
      CSR_MSCRATCH:  return mscratch_q;
      CSR_MEPC:      return mepc_q;
      CSR_MCAUSE:    return mcause_q;
      CSR_MTVAL:     return mtval_q;
      CSR_MIP:       return mip;
      CSR_MCYCLE:    return hi ? mcycle_v[63:32] : mcycle_v[31:0];
      CSR_MINSTRET:  return hi ? minstret_v[63:32] : minstret_v[31:0];
      CSR_MVENDORID: return VENDOR_ID;
      CSR_MARCHID:   return ARCH_ID;
      CSR_MIMPID:    return IMP_ID;
      CSR_MHARTID:   return HART_ID;
      default:       return 32'd0;
    endcase
  endfunction

  always_comb csr.readData = read_csr(csr.readCSR, csr.readHigh);
  always_comb wr_cur       = read_csr(wp.writeCSR, wp.writeHigh);
  assign wr_val = csr_alu(wp.writeOp, wr_cur, wp.writeOperand);

  always_comb begin
    irq_code = 4'd0;
    if (pend[IRQ_EXTERNAL])      irq_code = IRQ_EXTERNAL;
    else if (pend[IRQ_SOFTWARE]) irq_code = IRQ_SOFTWARE;
    else if (pend[IRQ_TIMER])    irq_code = IRQ_TIMER;
  end

  assign trap_take = csr.trapValid && (csr.trapIsInterrupt || csr.trapPayload.trapType != TRAP_NONE);
  assign write_go  = wp.writeEnable && wp.writeOp != CSR_NONE && !trap_take && !csr.mretValid;

  always_comb begin
    trap_code = csr.trapIsInterrupt ? irq_code : csr.trapPayload.trapType;
    trap_val  = 32'd0;
    if (!csr.trapIsInterrupt)
      case (csr.trapPayload.trapType)
        TRAP_ILLEGAL: trap_val = csr.trapPayload.instruction;
        TRAP_EBREAK:  trap_val = csr.trapPC;
        TRAP_MIS_INST, TRAP_ACCESS_INST, TRAP_MIS_LOAD, TRAP_ACCESS_LOAD,
        TRAP_MIS_STORE, TRAP_ACCESS_STORE: trap_val = csr.trapPayload.faultingAddress;
        default: ;
      endcase
  end

  always_comb begin
    mie_bit_d = mie_bit_q; mpie_d = mpie_q; mepc_d = mepc_q; mcause_d = mcause_q;
    mtval_d = mtval_q; mie_d = mie_q; mscratch_d = mscratch_q; mtvec_d = mtvec_q;
    if (trap_take) begin
      mepc_d    = {csr.trapPC[31:2], 2'b00};
      mpie_d    = mie_bit_q;
      mie_bit_d = 1'b0;
      mcause_d  = {csr.trapIsInterrupt, 27'b0, trap_code};
      mtval_d   = trap_val;
    end else if (csr.mretValid) begin
      mie_bit_d = mpie_q;
      mpie_d    = 1'b1;
    end else if (write_go) begin
      case (wp.writeCSR)
        CSR_MSTATUS:  begin mie_bit_d = wr_val[MSTATUS_MIE]; mpie_d = wr_val[MSTATUS_MPIE]; end
        CSR_MIE:      mie_d      = wr_val & MIE_MASK;
        CSR_MTVEC:    mtvec_d    = wr_val[1] ? {wr_val[31:2], 2'b00} : wr_val;
        CSR_MSCRATCH: mscratch_d = wr_val;
        CSR_MEPC:     mepc_d     = {wr_val[31:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = wr_val;
        CSR_MTVAL:    mtval_d    = wr_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mie_bit_q <= 1'b0; mpie_q <= 1'b0; mepc_q <= '0; mcause_q <= '0;
      mtval_q <= '0; mie_q <= '0; mscratch_q <= '0; mtvec_q <= MTVEC_RESET;
    end else begin
      mie_bit_q <= mie_bit_d; mpie_q <= mpie_d; mepc_q <= mepc_d; mcause_q <= mcause_d;
      mtval_q <= mtval_d; mie_q <= mie_d; mscratch_q <= mscratch_d; mtvec_q <= mtvec_d;
    end
  end

  csr_counter #(.WIDTH(COUNTER_WIDTH)) u_mcycle (
    .clock(clock), .reset(reset), .increment(1'b1),
    .writeLow (write_go && wp.writeCSR == CSR_MCYCLE && !wp.writeHigh),
    .writeHigh(write_go && wp.writeCSR == CSR_MCYCLE &&  wp.writeHigh),
    .data(wr_val), .value(mcycle_v)
  );

  csr_counter #(.WIDTH(COUNTER_WIDTH)) u_minstret (
    .clock(clock), .reset(reset), .increment(csr.instructionRetired),
    .writeLow (write_go && wp.writeCSR == CSR_MINSTRET && !wp.writeHigh),
    .writeHigh(write_go && wp.writeCSR == CSR_MINSTRET &&  wp.writeHigh),
    .data(wr_val), .value(minstret_v)
  );

  // Vectored mode offsets only interrupts; exceptions always go to the base.
  assign csr.trapVector = {mtvec_q[31:2], 2'b00} +
                          ((mtvec_q[1:0] == 2'b01 && csr.trapIsInterrupt) ? {26'b0, irq_code, 2'b00} : 32'd0);
  assign csr.mepcOut          = mepc_q;
  assign csr.interruptPending = mie_bit_q & (|pend);
  assign csr.interruptCode    = irq_code;
endmodule

// File: tb/tb_csr_unit.sv
// Directed checks of the CSR file: reset, WARL, counters, traps, MRET, interrupts.
module tb_csr_unit;
  import csr_unit_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   nchk = 0, nfail = 0;

  csr_unit_if bus();

  csr_unit #(.HART_ID(32'd5)) dut (.clock(clock), .reset(reset), .csr(bus));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic rd(input destinationCSR_ a, input logic hi, input logic [31:0] exp, input string tag);
    bus.readCSR = a; bus.readHigh = hi; #1;
    chk(tag, bus.readData, exp);
  endtask

  task automatic wr(input destinationCSR_ a, input CSROp_ op, input logic [31:0] v, input logic hi);
    bus.writeEnable = 1'b1; bus.writeCSR = a; bus.writeOp = op; bus.writeOperand = v; bus.writeHigh = hi;
    tick();
    bus.writeEnable = 1'b0; bus.writeOp = CSR_NONE; bus.writeHigh = 1'b0;
  endtask

  task automatic trap(input logic irq, input trapType_ t, input logic [31:0] pc,
                      input logic [31:0] ins, input logic [31:0] fa);
    bus.trapValid = 1'b1; bus.trapIsInterrupt = irq; bus.trapPC = pc;
    bus.trapPayload = '{trapType: t, instruction: ins, faultingAddress: fa};
  endtask

  task automatic untrap();
    bus.trapValid = 1'b0; bus.trapIsInterrupt = 1'b0;
    bus.trapPayload = '{trapType: TRAP_NONE, instruction: 32'd0, faultingAddress: 32'd0};
  endtask

  task automatic mret();
    bus.mretValid = 1'b1; tick(); bus.mretValid = 1'b0;
  endtask

  initial begin
    bus.readCSR = CSR_MSTATUS; bus.readHigh = 1'b0;
    bus.writeEnable = 1'b0; bus.writeCSR = CSR_MSCRATCH; bus.writeHigh = 1'b0;
    bus.writeOp = CSR_NONE; bus.writeOperand = 32'd0; bus.instructionRetired = 1'b0;
    bus.mretValid = 1'b0; bus.trapPC = 32'd0;
    bus.irqSoftware = 1'b0; bus.irqTimer = 1'b0; bus.irqExternal = 1'b0;
    untrap();

    repeat (2) tick();
    reset = 1'b0;
    chk("rst_pend", 32'(bus.interruptPending), 32'd0);
    rd(CSR_MTVEC,    1'b0, 32'h8000_0000, "rst_mtvec");
    rd(CSR_MSTATUS,  1'b0, 32'h0000_1800, "rst_mstatus");
    rd(CSR_MHARTID,  1'b0, 32'd5,         "rst_hartid");
    rd(CSR_MEPC,     1'b0, 32'd0,         "rst_mepc");
    rd(CSR_MINSTRET, 1'b0, 32'd0,         "rst_minstret");
    tick();

    wr(CSR_MIE, CSR_RS, 32'hFFFF_FFFF, 1'b0);
    rd(CSR_MIE, 1'b0, 32'h0000_0888, "mie_rs");
    wr(CSR_MIE, CSR_RC, 32'hFFFF_FFFF, 1'b0);
    rd(CSR_MIE, 1'b0, 32'd0, "mie_rc");
    wr(CSR_MISA, CSR_RW, 32'd0, 1'b0);
    rd(CSR_MISA, 1'b0, 32'h4000_0100, "misa_ro");
    wr(CSR_MHARTID, CSR_RW, 32'd9, 1'b0);
    rd(CSR_MHARTID, 1'b0, 32'd5, "hartid_ro");

    // Low write, then high write (low held), then two increments carry into the high half.
    wr(CSR_MCYCLE, CSR_RW, 32'hFFFF_FFFE, 1'b0);
    wr(CSR_MCYCLE, CSR_RW, 32'd0, 1'b1);
    rd(CSR_MCYCLE, 1'b0, 32'hFFFF_FFFE, "mcycle_lo0");
    rd(CSR_MCYCLE, 1'b1, 32'd0,         "mcycle_hi0");
    tick();
    rd(CSR_MCYCLE, 1'b0, 32'hFFFF_FFFF, "mcycle_lo1");
    tick();
    rd(CSR_MCYCLE, 1'b0, 32'd0, "mcycle_lo2");
    rd(CSR_MCYCLE, 1'b1, 32'd1, "mcycle_hi2");

    bus.instructionRetired = 1'b1;
    repeat (3) tick();
    bus.instructionRetired = 1'b0;
    rd(CSR_MINSTRET, 1'b0, 32'd3, "minstret_lo");
    rd(CSR_MINSTRET, 1'b1, 32'd0, "minstret_hi");

    wr(CSR_MSTATUS, CSR_RS, 32'h0000_0008, 1'b0);
    rd(CSR_MSTATUS, 1'b0, 32'h0000_1808, "mstatus_mie1");

    // Trap with a coincident write: the write must be dropped.
    trap(1'b0, TRAP_ILLEGAL, 32'h8000_0104, 32'hFFFF_FFFF, 32'h0);
    bus.writeEnable = 1'b1; bus.writeCSR = CSR_MSCRATCH; bus.writeOp = CSR_RW; bus.writeOperand = 32'hDEAD;
    #1 chk("ill_vector", bus.trapVector, 32'h8000_0000);
    tick();
    untrap(); bus.writeEnable = 1'b0; bus.writeOp = CSR_NONE;
    rd(CSR_MEPC,     1'b0, 32'h8000_0104, "ill_mepc");
    rd(CSR_MCAUSE,   1'b0, 32'd2,         "ill_mcause");
    rd(CSR_MTVAL,    1'b0, 32'hFFFF_FFFF, "ill_mtval");
    rd(CSR_MSTATUS,  1'b0, 32'h0000_1880, "ill_mstatus");
    rd(CSR_MSCRATCH, 1'b0, 32'd0,         "ill_wr_dropped");
    chk("ill_mepcout", bus.mepcOut, 32'h8000_0104);

    bus.writeEnable = 1'b1; bus.writeCSR = CSR_MSCRATCH; bus.writeOp = CSR_RW; bus.writeOperand = 32'h5555;
    mret();
    bus.writeEnable = 1'b0; bus.writeOp = CSR_NONE;
    rd(CSR_MSTATUS,  1'b0, 32'h0000_1888, "mret_mstatus");
    rd(CSR_MSCRATCH, 1'b0, 32'd0,         "mret_wr_dropped");

    bus.writeEnable = 1'b1; bus.writeCSR = CSR_MSCRATCH; bus.writeOp = CSR_RW; bus.writeOperand = 32'h1234;
    rd(CSR_MSCRATCH, 1'b0, 32'd0, "no_bypass");
    tick();
    bus.writeEnable = 1'b0; bus.writeOp = CSR_NONE;
    rd(CSR_MSCRATCH, 1'b0, 32'h1234, "scratch_rw");
    wr(CSR_MSCRATCH, CSR_RS, 32'h0000_F000, 1'b0);
    rd(CSR_MSCRATCH, 1'b0, 32'h0000_F234, "scratch_rs");
    wr(CSR_MSCRATCH, CSR_RC, 32'h0000_0234, 1'b0);
    rd(CSR_MSCRATCH, 1'b0, 32'h0000_F000, "scratch_rc");

    wr(CSR_MTVEC, CSR_RW, 32'h8000_1001, 1'b0);
    rd(CSR_MTVEC, 1'b0, 32'h8000_1001, "mtvec_vec");
    wr(CSR_MIE, CSR_RW, 32'h0000_0080, 1'b0);
    bus.irqTimer = 1'b1;
    #1 chk("tmr_pend", 32'(bus.interruptPending), 32'd1);
    chk("tmr_code", 32'(bus.interruptCode), 32'd7);
    rd(CSR_MIP, 1'b0, 32'h0000_0080, "tmr_mip");
    trap(1'b1, TRAP_NONE, 32'h8000_0040, 32'h0, 32'h0);
    #1 chk("tmr_vector", bus.trapVector, 32'h8000_101C);
    tick();
    untrap();
    rd(CSR_MCAUSE,  1'b0, 32'h8000_0007, "tmr_mcause");
    rd(CSR_MEPC,    1'b0, 32'h8000_0040, "tmr_mepc");
    rd(CSR_MTVAL,   1'b0, 32'd0,         "tmr_mtval");
    rd(CSR_MSTATUS, 1'b0, 32'h0000_1880, "tmr_mstatus");
    chk("tmr_pend_off", 32'(bus.interruptPending), 32'd0);

    mret();
    wr(CSR_MIE, CSR_RW, 32'h0000_0FFF, 1'b0);
    rd(CSR_MIE, 1'b0, 32'h0000_0888, "mie_warl");
    bus.irqSoftware = 1'b1;
    #1 chk("sw_code", 32'(bus.interruptCode), 32'd3);
    bus.irqExternal = 1'b1;
    #1 chk("ext_code", 32'(bus.interruptCode), 32'd11);
    rd(CSR_MIP, 1'b0, 32'h0000_0888, "all_mip");
    trap(1'b1, TRAP_NONE, 32'h8000_0050, 32'h0, 32'h0);
    #1 chk("ext_vector", bus.trapVector, 32'h8000_102C);
    untrap();
    bus.irqSoftware = 1'b0; bus.irqTimer = 1'b0; bus.irqExternal = 1'b0;

    wr(CSR_MTVEC, CSR_RW, 32'h8000_2003, 1'b0);
    rd(CSR_MTVEC, 1'b0, 32'h8000_2000, "mtvec_warl");
    wr(CSR_MSTATUS, CSR_RW, 32'd0, 1'b0);
    rd(CSR_MSTATUS, 1'b0, 32'h0000_1800, "mstatus_clr");
    wr(CSR_MSTATUS, CSR_RW, 32'hFFFF_FFFF, 1'b0);
    rd(CSR_MSTATUS, 1'b0, 32'h0000_1888, "mstatus_warl");
    wr(CSR_MEPC, CSR_RW, 32'h8000_0007, 1'b0);
    rd(CSR_MEPC, 1'b0, 32'h8000_0004, "mepc_warl");

    trap(1'b0, TRAP_EBREAK, 32'h8000_0203, 32'h0, 32'h0);
    #1 chk("ebk_vector", bus.trapVector, 32'h8000_2000);
    tick();
    untrap();
    rd(CSR_MEPC,   1'b0, 32'h8000_0200, "ebk_mepc");
    rd(CSR_MCAUSE, 1'b0, 32'd3,         "ebk_mcause");
    rd(CSR_MTVAL,  1'b0, 32'h8000_0203, "ebk_mtval");

    trap(1'b0, TRAP_MIS_LOAD, 32'h8000_0300, 32'h1234_5678, 32'h0000_1001);
    tick();
    untrap();
    rd(CSR_MCAUSE, 1'b0, 32'd4,         "mld_mcause");
    rd(CSR_MTVAL,  1'b0, 32'h0000_1001, "mld_mtval");

    trap(1'b0, TRAP_NONE, 32'h8000_0400, 32'h0, 32'h0);
    tick();
    untrap();
    rd(CSR_MCAUSE, 1'b0, 32'd4,         "none_ignored");
    rd(CSR_MEPC,   1'b0, 32'h8000_0300, "none_mepc");

    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd(CSR_MSCRATCH, 1'b0, 32'd0,         "rst2_scratch");
    rd(CSR_MTVEC,    1'b0, 32'h8000_0000, "rst2_mtvec");
    rd(CSR_MSTATUS,  1'b0, 32'h0000_1800, "rst2_mstatus");
    rd(CSR_MCAUSE,   1'b0, 32'd0,         "rst2_mcause");
    rd(CSR_MIE,      1'b0, 32'd0,         "rst2_mie");
    tick();
    rd(CSR_MEPC,     1'b0, 32'd0, "rst2_mepc");
    rd(CSR_MTVAL,    1'b0, 32'd0, "rst2_mtval");
    rd(CSR_MINSTRET, 1'b0, 32'd0, "rst2_minstret");

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
